seven_seg_scan: RTL and testbench

//  Time-multiplexed driver for an active-low 8-digit seven-segment display.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/hex_to_seg.sv | 35 +++
 rtl/seven_seg_scan.sv | 133 +++++++++++++
 tb/tb_seven_seg_scan.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : seven_seg_pkg                                           |
// | Active-low segment codes, anode constants, scan FSM states.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package seven_seg_pkg;
   // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_ALL_OFF = 8'hFF;

   typedef enum logic [0:0] {
      ST_DEAD = 1'b0,
      ST_ON   = 1'b1
   } scan_state_t;
endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : hex_to_seg                                              |
// | Combinational hex nibble to active-low seven-segment decoder.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seven_seg_scan                                          |
// | Multiplexed active-low 8-digit display driver with anode dead     |
// | time and per-frame data latching. Define SEVEN_SEG_LZ_BLANK_EN    |
// | for leading-zero blanking.                                        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int DEAD_CYCLES = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        DividedClock,
   input  logic [31:0] Data,
   input  logic [7:0]  DpIn,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic [2:0]  DigitIdx,
   output logic        FrameStart
);
   localparam int               c_cnt_w      = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_dead_load = c_cnt_w'((DEAD_CYCLES == 0) ? 1 : DEAD_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
   localparam logic [2:0]       c_last_digit = 3'(NUM_DIGITS - 1);

   scan_state_t        r_state;
   logic               r_div_q;
   logic [c_cnt_w-1:0] r_dead_cnt;
   logic [2:0]         r_digit_idx;
   logic [31:0]        r_shadow_data;
   logic [7:0]         r_shadow_dp;
   logic [7:0]         r_an;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic               r_frame_start;

   logic               w_step;
   logic [2:0]         w_next_idx;
   logic [3:0]         w_nibble;
   logic [6:0]         w_seg;
   logic [6:0]         w_seg_shown;
   logic [7:0]         w_an_on;

   assign w_step     = DividedClock & ~r_div_q;
   assign w_next_idx = (r_digit_idx == c_last_digit) ? 3'd0 : r_digit_idx + 3'd1;
   assign w_nibble   = r_shadow_data[{r_digit_idx, 2'b00} +: 4];
   assign w_an_on    = AN_ALL_OFF & ~(8'h01 << r_digit_idx);

   hex_to_seg u_hex_to_seg (
      .nibble (w_nibble),
      .seg    (w_seg)
   );

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic [7:0] r_blank;
   logic [7:0] w_blank_next;

   // Digit k blanks when it and every nibble above it are zero; digit 0 always shows
   always_comb begin
      logic zero_above;
      w_blank_next = '0;
      zero_above   = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         zero_above      = zero_above & (Data[4*k +: 4] == 4'h0);
         w_blank_next[k] = zero_above;
      end
   end

   assign w_seg_shown = r_blank[r_digit_idx] ? SEG_BLANK : w_seg;
`else
   assign w_seg_shown = w_seg;
`endif

   // Dead counter: 0 = idle (nothing pending), 1 = light the digit on this edge
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state       <= ST_DEAD;
         r_div_q       <= 1'b1;
         r_dead_cnt    <= '0;
         r_digit_idx   <= c_last_digit;
         r_shadow_data <= '0;
         r_shadow_dp   <= '0;
         r_an          <= AN_ALL_OFF;
         r_seg         <= SEG_BLANK;
         r_dp          <= 1'b1;
         r_frame_start <= 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
         r_blank       <= '0;
`endif
      end else begin
         r_div_q       <= DividedClock;
         r_frame_start <= 1'b0;
         if (w_step) begin
            r_state     <= ST_DEAD;
            r_dead_cnt  <= c_dead_load;
            r_digit_idx <= w_next_idx;
            r_an        <= AN_ALL_OFF;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
            if (w_next_idx == 3'd0) begin
               r_shadow_data <= Data;
               r_shadow_dp   <= DpIn;
               r_frame_start <= 1'b1;
`ifdef SEVEN_SEG_LZ_BLANK_EN
               r_blank       <= w_blank_next;
`endif
            end
         end else if (r_state == ST_DEAD) begin
            if (r_dead_cnt == c_cnt_one) begin
               r_state    <= ST_ON;
               r_dead_cnt <= '0;
               r_an       <= w_an_on;
               r_seg      <= w_seg_shown;
               r_dp       <= ~r_shadow_dp[r_digit_idx];
            end else if (r_dead_cnt != '0) begin
               r_dead_cnt <= r_dead_cnt - c_cnt_one;
            end
         end
      end
   end

   assign AN         = r_an;
   assign SEG        = r_seg;
   assign DP         = r_dp;
   assign DigitIdx   = r_digit_idx;
   assign FrameStart = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_seven_seg_scan                                       |
// | Table-driven bench for seven_seg_scan (honours SEVEN_SEG_LZ_BLANK_EN).|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_seven_seg_scan;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_clk;
   logic [31:0] data = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  digit_idx;
   logic        frame_start;

`ifdef SEVEN_SEG_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int onehot_bad = 0;

   seven_seg_scan #(.NUM_DIGITS(8), .DEAD_CYCLES(16)) dut (
      .Clock        (clk),
      .Reset        (rst),
      .DividedClock (div_clk),
      .Data         (data),
      .DpIn         (dp_in),
      .AN           (an),
      .SEG          (seg),
      .DP           (dp),
      .DigitIdx     (digit_idx),
      .FrameStart   (frame_start)
   );

   always #5 clk = ~clk;

   // Divider model: toggles every 200 clocks while running
   logic       div_run = 1'b0;
   logic       div_rise = 1'b0;
   int         dcnt = 0;
   initial div_clk = 1'b0;
   always @(posedge clk) begin
      if (!div_run) begin
         dcnt     <= 0;
         div_clk  <= 1'b0;
         div_rise <= 1'b0;
      end else begin
         div_rise <= 1'b0;
         if (dcnt == 199) begin
            dcnt     <= 0;
            div_clk  <= ~div_clk;
            div_rise <= ~div_clk;
         end else begin
            dcnt <= dcnt + 1;
         end
      end
   end

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp_in;
      logic [2:0]  digit;
      logic        fs;
      logic [3:0]  nib;
      logic        blank;
      logic        dp_exp;
   } vec_t;

   vec_t       vecs[48];
   int         nv = 0;
   logic [6:0] seg_tab[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] d, input logic [7:0] p, input int dig,
                      input logic fs, input logic [3:0] nib, input logic blank, input logic dpx);
      vecs[nv] = '{d, p, 3'(dig), fs, nib, blank, dpx};
      nv++;
   endtask

   task automatic step_check(input vec_t v);
      bit         found = 0;
      bit         dead_ok = 1;
      logic [6:0] seg_exp;
      data  = v.data;
      dp_in = v.dp_in;
      for (int n = 0; n < 600 && !found; n++) begin
         @(negedge clk);
         if ($countones(~an) > 1) onehot_bad++;
         if (div_rise) found = 1;
      end
      if (!found) begin
         chk("step_timeout", 32'd0, 32'd1);
         return;
      end
      @(posedge clk); #1;
      chk("frame_start", {31'd0, frame_start}, {31'd0, v.fs});
      if (an !== 8'hFF) dead_ok = 0;
      for (int n = 1; n < 16; n++) begin
         @(posedge clk); #1;
         if (an !== 8'hFF || frame_start !== 1'b0) dead_ok = 0;
      end
      chk("dead_phase", {31'd0, dead_ok}, 32'd1);
      @(posedge clk); #1;
      seg_exp = (v.blank && LZ) ? 7'h7F : seg_tab[v.nib];
      chk("an_on", {24'd0, an}, {24'd0, 8'hFF ^ (8'h01 << v.digit)});
      chk("seg_on", {25'd0, seg}, {25'd0, seg_exp});
      chk("dp_on", {31'd0, dp}, {31'd0, v.dp_exp});
      chk("digit_idx", {29'd0, digit_idx}, {29'd0, v.digit});
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      // Frame 76543210: full rotation and back to digit 0
      for (int k = 0; k <= 8; k++)
         add(32'h76543210, 8'h01, k % 8, (k % 8) == 0, 4'(k % 8), 1'b0, (k % 8) != 0);
      for (int k = 1; k <= 3; k++) add(32'h76543210, 8'h01, k, 1'b0, 4'(k), 1'b0, 1'b1);
      // Data changed while digit 3 shown; rest of frame keeps old values
      for (int k = 4; k <= 7; k++) add(32'hFFFFFFFF, 8'h01, k, 1'b0, 4'(k), 1'b0, 1'b1);
      add(32'hFFFFFFFF, 8'h01, 0, 1'b1, 4'hF, 1'b0, 1'b0);
      for (int k = 1; k <= 2; k++) add(32'hFFFFFFFF, 8'h01, k, 1'b0, 4'hF, 1'b0, 1'b1);
      for (int k = 3; k <= 7; k++) add(32'h00000A05, 8'h01, k, 1'b0, 4'hF, 1'b0, 1'b1);
      add(32'h00000A05, 8'h01, 0, 1'b1, 4'h5, 1'b0, 1'b0);
      add(32'h00000A05, 8'h01, 1, 1'b0, 4'h0, 1'b0, 1'b1);
      add(32'h00000A05, 8'h01, 2, 1'b0, 4'hA, 1'b0, 1'b1);
      for (int k = 3; k <= 7; k++) add(32'h0, 8'h01, k, 1'b0, 4'h0, 1'b1, 1'b1);
      add(32'h0, 8'h01, 0, 1'b1, 4'h0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) add(32'h0, 8'h01, k, 1'b0, 4'h0, 1'b1, 1'b1);
      add(32'h0, 8'h01, 0, 1'b1, 4'h0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) add(32'h0, 8'h01, k, 1'b0, 4'h0, 1'b1, 1'b1);

      // Reset held 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_an", {24'd0, an}, 32'hFF);
         chk("rst_seg", {25'd0, seg}, 32'h7F);
         chk("rst_dp", {31'd0, dp}, 32'd1);
         chk("rst_fs", {31'd0, frame_start}, 32'd0);
         chk("rst_idx", {29'd0, digit_idx}, 32'd7);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_an", {24'd0, an}, 32'hFF);
      chk("post_rst_fs", {31'd0, frame_start}, 32'd0);

      div_run = 1'b1;
      for (int i = 0; i < nv; i++) step_check(vecs[i]);

      // Async reset during ON phase of digit 5
      #2;
      rst = 1'b1;
      div_run = 1'b0;
      #1;
      chk("async_rst_an", {24'd0, an}, 32'hFF);
      chk("async_rst_seg", {25'd0, seg}, 32'h7F);
      chk("async_rst_idx", {29'd0, digit_idx}, 32'd7);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      div_run = 1'b1;
      step_check('{32'h00000008, 8'h00, 3'd0, 1'b1, 4'h8, 1'b0, 1'b1});

      chk("an_onehot", onehot_bad, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
